// File: rtl/reorder_buffer_if.sv
// Handshake bundle between decode/writeback/free-list logic and the reorder buffer.
// The ROB side uses the slave modport; the surrounding pipeline uses master.
interface reorder_buffer_if #(
    parameter int ROB_WIDTH  = 4,
    parameter int PREG_WIDTH = 6
);
    // Allocation from decode
    logic                  alloc_valid;
    logic                  alloc_ready;
    logic                  alloc_has_dest;
    logic [PREG_WIDTH-1:0] alloc_old_preg;
    logic [ROB_WIDTH-1:0]  alloc_index;
    // Writeback completion
    logic                  wb_valid;
    logic [ROB_WIDTH-1:0]  wb_index;
    // Retirement towards the free list
    logic                  retire_valid;
    logic                  retire_ready;
    logic                  retire_has_dest;
    logic [PREG_WIDTH-1:0] retire_free_preg;
    // Squash and occupancy status
    logic                  flush;
    logic [ROB_WIDTH:0]    count;
    logic                  full;
    logic                  empty;

    modport master (
        output alloc_valid, alloc_has_dest, alloc_old_preg,
        output wb_valid, wb_index,
        output retire_ready, flush,
        input  alloc_ready, alloc_index,
        input  retire_valid, retire_has_dest, retire_free_preg,
        input  count, full, empty
    );

    modport slave (
        input  alloc_valid, alloc_has_dest, alloc_old_preg,
        input  wb_valid, wb_index,
        input  retire_ready, flush,
        output alloc_ready, alloc_index,
        output retire_valid, retire_has_dest, retire_free_preg,
        output count, full, empty
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: entries are allocated at the tail in program
// order, marked done by out-of-order writeback, and retired from the head
// once complete, returning the previous destination mapping to the free list.
module reorder_buffer #(
    parameter int ROB_WIDTH  = 4,
    parameter int PREG_WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    reorder_buffer_if.slave  rob
);
    localparam int DEPTH = 1 << ROB_WIDTH;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [ROB_WIDTH:0]    head;
    logic [ROB_WIDTH:0]    tail;
    logic [ROB_WIDTH-1:0]  head_idx;
    logic [ROB_WIDTH-1:0]  tail_idx;

    // Per-entry state: valid/done are control, has_dest/old_preg are payload.
    logic [DEPTH-1:0]      valid;
    logic [DEPTH-1:0]      done;
    logic [DEPTH-1:0]      has_dest;
    logic [PREG_WIDTH-1:0] old_preg [DEPTH];

    logic                  full_int;
    logic                  empty_int;
    logic                  retire_valid_int;
    logic                  alloc_fire;
    logic                  retire_fire;
    logic                  wb_hit;

    assign head_idx = head[ROB_WIDTH-1:0];
    assign tail_idx = tail[ROB_WIDTH-1:0];

    assign full_int  = (head[ROB_WIDTH] != tail[ROB_WIDTH]) && (head_idx == tail_idx);
    assign empty_int = (head == tail);

    assign retire_valid_int = !empty_int && done[head_idx];

    // Allocation is gated by the current full state only, so a retirement in
    // the same cycle does not open a slot until the following cycle.
    assign alloc_fire  = rob.alloc_valid && !full_int;
    assign retire_fire = retire_valid_int && rob.retire_ready;
    assign wb_hit      = rob.wb_valid && valid[rob.wb_index];

    assign rob.alloc_ready      = !full_int;
    assign rob.alloc_index      = tail_idx;
    assign rob.retire_valid     = retire_valid_int;
    assign rob.retire_has_dest  = has_dest[head_idx];
    assign rob.retire_free_preg = old_preg[head_idx];
    assign rob.count            = tail - head;
    assign rob.full             = full_int;
    assign rob.empty            = empty_int;

    // Pointer and valid/done tracking; flush outranks alloc, wb and retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            valid <= '0;
            done  <= '0;
        end else if (rob.flush) begin
            head  <= '0;
            tail  <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            if (wb_hit) begin
                done[rob.wb_index] <= 1'b1;
            end
            if (retire_fire) begin
                valid[head_idx] <= 1'b0;
                done[head_idx]  <= 1'b0;
                head            <= head + 1'b1;
            end
            // Last assignment wins so a fresh entry always starts not-done.
            if (alloc_fire) begin
                valid[tail_idx] <= 1'b1;
                done[tail_idx]  <= 1'b0;
                tail            <= tail + 1'b1;
            end
        end
    end

    // Entry payload capture; meaningful only while the entry is valid.
    always_ff @(posedge clk) begin
        if (alloc_fire && !rob.flush) begin
            has_dest[tail_idx] <= rob.alloc_has_dest;
            old_preg[tail_idx] <= rob.alloc_old_preg;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: ordered retirement, full/empty limits,
// same-cycle alloc/retire, pointer wrap, flush and asynchronous reset.
module tb_reorder_buffer;
    localparam int RW    = 4;
    localparam int PW    = 6;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   ret_cnt;
    int   exp_cnt;
    int   alloc_n;
    int   ret_n;

    reorder_buffer_if #(.ROB_WIDTH(RW), .PREG_WIDTH(PW)) bus ();

    reorder_buffer #(.ROB_WIDTH(RW), .PREG_WIDTH(PW)) dut (
        .clk (clk),
        .rst (rst),
        .rob (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_valid    = 1'b0;
        bus.alloc_has_dest = 1'b0;
        bus.alloc_old_preg = '0;
        bus.wb_valid       = 1'b0;
        bus.wb_index       = '0;
        bus.retire_ready   = 1'b0;
        bus.flush          = 1'b0;
    endtask

    task automatic alloc(input int hd, input int preg);
        logic [PW-1:0] p;
        p = preg[PW-1:0];
        bus.alloc_valid    = 1'b1;
        bus.alloc_has_dest = (hd != 0);
        bus.alloc_old_preg = p;
        cycle();
        bus.alloc_valid    = 1'b0;
        #1;
    endtask

    task automatic wb(input int idx);
        logic [RW-1:0] w;
        w = idx[RW-1:0];
        bus.wb_valid = 1'b1;
        bus.wb_index = w;
        cycle();
        bus.wb_valid = 1'b0;
        #1;
    endtask

    task automatic check_reset(input string pfx);
        chk({pfx, "_count"},        int'(bus.count), 0);
        chk({pfx, "_empty"},        int'(bus.empty), 1);
        chk({pfx, "_full"},         int'(bus.full), 0);
        chk({pfx, "_alloc_ready"},  int'(bus.alloc_ready), 1);
        chk({pfx, "_retire_valid"}, int'(bus.retire_valid), 0);
        chk({pfx, "_alloc_index"},  int'(bus.alloc_index), 0);
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        rst = 1'b0;
        cycle();
        check_reset("post_rst");

        // Three allocations, out-of-order writeback, in-order retirement
        alloc(1, 40);
        alloc(1, 41);
        alloc(1, 42);
        chk("a3_count", int'(bus.count), 3);
        chk("a3_alloc_index", int'(bus.alloc_index), 3);
        wb(1);
        chk("wb1_retire_valid", int'(bus.retire_valid), 0);
        wb(0);
        chk("wb0_retire_valid", int'(bus.retire_valid), 1);
        chk("wb0_free_preg", int'(bus.retire_free_preg), 40);
        chk("wb0_has_dest", int'(bus.retire_has_dest), 1);
        bus.retire_ready = 1'b1;
        cycle();
        chk("ret0_retire_valid", int'(bus.retire_valid), 1);
        chk("ret0_free_preg", int'(bus.retire_free_preg), 41);
        chk("ret0_count", int'(bus.count), 2);
        cycle();
        chk("ret1_retire_valid", int'(bus.retire_valid), 0);
        chk("ret1_count", int'(bus.count), 1);
        bus.retire_ready = 1'b0;
        do_flush();
        chk("flush1_empty", int'(bus.empty), 1);

        // Fill to capacity; has_dest alternates so index 0 has none
        for (int i = 0; i < DEPTH; i++) begin
            alloc(i % 2, 20 + i);
        end
        chk("fill_full", int'(bus.full), 1);
        chk("fill_alloc_ready", int'(bus.alloc_ready), 0);
        chk("fill_count", int'(bus.count), 16);
        chk("fill_alloc_index", int'(bus.alloc_index), 0);
        alloc(1, 63);
        chk("over_count", int'(bus.count), 16);
        chk("over_alloc_index", int'(bus.alloc_index), 0);
        chk("over_full", int'(bus.full), 1);

        // Full buffer: concurrent alloc and retire -> retirement only
        wb(0);
        chk("fr_retire_valid", int'(bus.retire_valid), 1);
        chk("fr_has_dest", int'(bus.retire_has_dest), 0);
        chk("fr_free_preg", int'(bus.retire_free_preg), 20);
        bus.alloc_valid    = 1'b1;
        bus.alloc_has_dest = 1'b1;
        bus.alloc_old_preg = 6'd50;
        bus.retire_ready   = 1'b1;
        #1;
        chk("fr_alloc_ready", int'(bus.alloc_ready), 0);
        cycle();
        bus.retire_ready = 1'b0;
        #1;
        chk("fr_count", int'(bus.count), 15);
        chk("fr_alloc_index", int'(bus.alloc_index), 0);
        chk("fr_full", int'(bus.full), 0);
        chk("fr_head_retire_valid", int'(bus.retire_valid), 0);
        cycle();
        bus.alloc_valid = 1'b0;
        #1;
        chk("fr2_count", int'(bus.count), 16);
        chk("fr2_alloc_index", int'(bus.alloc_index), 1);
        chk("fr2_full", int'(bus.full), 1);
        do_flush();
        check_reset("flush2");

        // 40 streamed entries: alloc i, wb i-1, retire i-2 each cycle
        ret_cnt = 0;
        bus.retire_ready   = 1'b1;
        bus.alloc_has_dest = 1'b1;
        for (int i = 0; i < 42; i++) begin
            bus.alloc_valid    = (i < 40);
            bus.alloc_old_preg = 6'(i);
            bus.wb_valid       = (i >= 1) && (i <= 40);
            bus.wb_index       = 4'((i + 15) % 16);
            #1;
            alloc_n = (i < 40) ? i : 40;
            ret_n   = (i < 2) ? 0 : ((i - 2 > 40) ? 40 : i - 2);
            exp_cnt = alloc_n - ret_n;
            chk("str_count", int'(bus.count), exp_cnt);
            chk("str_count_le16", int'(bus.count <= 16), 1);
            if (i < 40) begin
                chk("str_alloc_index", int'(bus.alloc_index), i % 16);
            end
            chk("str_retire_valid", int'(bus.retire_valid), int'(i >= 2));
            if (bus.retire_valid) begin
                chk("str_order", int'(bus.retire_free_preg), ret_cnt);
                ret_cnt++;
            end
            cycle();
        end
        idle();
        #1;
        chk("str_retired", ret_cnt, 40);
        chk("str_end_count", int'(bus.count), 0);
        chk("str_end_empty", int'(bus.empty), 1);
        chk("str_end_alloc_index", int'(bus.alloc_index), 8);

        // Five in flight, then flush with concurrent alloc, wb and retire
        for (int i = 0; i < 5; i++) begin
            alloc(1, 30 + i);
        end
        wb(9);
        wb(8);
        chk("pre_flush_count", int'(bus.count), 5);
        chk("pre_flush_retire_valid", int'(bus.retire_valid), 1);
        bus.flush        = 1'b1;
        bus.alloc_valid  = 1'b1;
        bus.wb_valid     = 1'b1;
        bus.wb_index     = 4'd10;
        bus.retire_ready = 1'b1;
        cycle();
        idle();
        #1;
        check_reset("flush3");
        cycle();
        chk("flush3_hold_count", int'(bus.count), 0);

        // Asynchronous reset between clock edges with four entries
        alloc(1, 10);
        alloc(1, 11);
        alloc(1, 12);
        alloc(1, 13);
        wb(0);
        chk("pre_rst_count", int'(bus.count), 4);
        chk("pre_rst_retire_valid", int'(bus.retire_valid), 1);
        #1;
        rst = 1'b1;
        #1;
        check_reset("rst_mid");
        rst = 1'b0;
        wb(2);
        chk("stale_wb_count", int'(bus.count), 0);
        chk("stale_wb_retire_valid", int'(bus.retire_valid), 0);
        chk("stale_wb_empty", int'(bus.empty), 1);
        alloc(0, 5);
        chk("post_rst_count", int'(bus.count), 1);
        chk("post_rst_alloc_index", int'(bus.alloc_index), 1);
        chk("post_rst_retire_valid", int'(bus.retire_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
